axi_burst_master: RTL and testbench
===================================

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, AXI data width; ADDR_WIDTH, 16, byte address width; STRB_WIDTH, DATA_WIDTH/8, strobe width; ID_WIDTH, 8, AXI ID width.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-005 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-006 cmd_addr/cmd_len/cmd_id  in  ADDR_WIDTH/8/ID_WIDTH  start byte address, beats-1, transaction ID.
REQ-007 wr_data/wr_strb/wr_valid/wr_ready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  write-data stream.
REQ-008 rd_data/rd_last/rd_valid/rd_ready  out/out/out/in  DATA_WIDTH/1/1/1  read-data stream.
REQ-009 done/done_err  out  1/1  one-cycle completion pulse; error qualifier valid with done.
REQ-010 m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}  out, m_axi_awready  in  AXI4 write address channel, standard widths.
REQ-011 m_axi_w{data,strb,last,valid}  out, m_axi_wready  in  write data channel.
REQ-012 m_axi_b{id,resp,valid}  in, m_axi_bready  out  write response channel.
REQ-013 m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  out, m_axi_arready  in  read address channel.
REQ-014 m_axi_r{id,data,resp,last,valid}  in, m_axi_rready  out  read data channel.

Function
REQ-015 The FSM SHALL have states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA; one transaction outstanding at a time.
REQ-016 cmd_ready SHALL be registered and high only in IDLE; on cmd_valid&&cmd_ready, fields SHALL be latched, state -> WR_ADDR or RD_ADDR per cmd_write, and cmd_ready SHALL drop on the next cycle.
REQ-017 The latched address SHALL have its low log2(STRB_WIDTH) bits forced to zero.
REQ-018 Address channels SHALL drive: size = log2(STRB_WIDTH), burst = 2'b01 (INCR), lock = 0, cache = 4'b0011, prot = 3'b000, len = cmd_len, id = cmd_id.
REQ-019 The AW/AR valid signal SHALL be registered, rise the cycle after command acceptance, and stay high with stable payload until the ready handshake; on handshake, state -> WR_DATA or RD_DATA.
REQ-020 In WR_DATA: m_axi_wvalid = wr_valid, wr_ready = m_axi_wready, and data/strb SHALL pass straight through; outside WR_DATA, wr_ready = 0 and m_axi_wvalid = 0.
REQ-021 A beat counter SHALL count W handshakes; m_axi_wlast SHALL be high when count == latched len; the last handshake SHALL transition to WR_RESP.
REQ-022 In WR_RESP, m_axi_bready = 1; on B handshake: done = 1 next cycle, done_err = (bresp != 2'b00), state -> IDLE.
REQ-023 In RD_DATA: rd_valid = m_axi_rvalid, m_axi_rready = rd_ready, rd_data = rdata, rd_last = rlast.
REQ-024 A sticky read error SHALL OR together (rresp != 2'b00) over all beats and SHALL be cleared on command acceptance.
REQ-025 The read burst SHALL end on the R handshake with rlast = 1; done_err = sticky error OR (beats received != len+1).
REQ-026 If beat len+1 arrives without rlast, RD_DATA SHALL continue until rlast, and done_err SHALL be set.
REQ-027 4 KB boundary crossing SHALL NOT be checked; it is the caller's responsibility.
REQ-028 cmd_ready SHALL return high the cycle after the done pulse.

Reset
REQ-029 While rst_n = 0: state = IDLE, and cmd_ready, done, done_err, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready, wr_ready, rd_valid SHALL all be 0.
REQ-030 cmd_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-031 Reset asserted mid-burst SHALL abort immediately without a done pulse.

Configuration
REQ-032 With AXI_BURST_MASTER_ID_CHECK_EN defined, a bid or rid not equal to the latched ID SHALL set done_err for that transaction.
REQ-033 Without AXI_BURST_MASTER_ID_CHECK_EN, bid and rid SHALL be ignored.

Verification
REQ-034 Write cmd addr 0x0103, len 3, id 0x5A, ready always high -> awaddr 0x0100, awlen 3, awsize 2, 4 W beats with wlast on the 4th, bready, then done = 1, done_err = 0.
REQ-035 Read cmd addr 0x0200, len 7, slave returns 8 beats with OKAY, rd_ready toggling 50% -> 8 rd beats in order, rd_last on the 8th only, done, no error.
REQ-036 Read len 1 with rresp = 2'b10 on beat 0 -> done_err = 1 at done.
REQ-037 Read len 3 with rlast on beat 2 -> done after beat 2, done_err = 1.
REQ-038 awready held low 10 cycles -> awvalid held high and awaddr stable throughout; rst_n pulsed low mid-W -> all valids 0 the same cycle, no done.
REQ-039 With the macro defined, bid = 0x11 against issued id 0x22 -> done_err = 1; without the macro -> done_err = 0.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// Bundled command, user data streams and AXI4 master channels for axi_burst_master.
// master modport is the burst engine's view; slave modport is the surrounding system's view.
interface axi_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic [ID_WIDTH-1:0]   cmd_id;

    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  rd_valid;
    logic                  rd_ready;
    logic                  done;
    logic                  done_err;

    logic [ID_WIDTH-1:0]   m_axi_awid;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awlock;
    logic [3:0]            m_axi_awcache;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [ID_WIDTH-1:0]   m_axi_bid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
        output cmd_ready,
        input  wr_data, wr_strb, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_last, rd_valid, done, done_err,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
        input  cmd_ready,
        output wr_data, wr_strb, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_last, rd_valid, done, done_err,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master driven by a command port and data streams.
// Define AXI_BURST_MASTER_ID_CHECK_EN to flag bid/rid mismatches in done_err.
module axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_burst_master_if.master    bus
);
    localparam int                    SIZE_BITS = $clog2(STRB_WIDTH);
    localparam logic [2:0]            AXI_SIZE  = 3'(SIZE_BITS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'((1 << SIZE_BITS) - 1));

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5
    } state_t;

    state_t                state_r, state_next_s;
    logic                  cmd_ready_r, cmd_ready_next_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_next_s;
    logic [7:0]            len_r, len_next_s;
    logic [ID_WIDTH-1:0]   id_r, id_next_s;
    logic                  awvalid_r, awvalid_next_s;
    logic                  arvalid_r, arvalid_next_s;
    logic [7:0]            beat_cnt_r, beat_cnt_next_s;
    logic                  rd_err_r, rd_err_next_s;
    logic                  done_r, done_next_s;
    logic                  done_err_r, done_err_next_s;

    logic cmd_hs_s, aw_hs_s, ar_hs_s, w_hs_s, b_hs_s, r_hs_s;
    logic wvalid_s, wlast_s, bid_err_s, rid_err_s, rd_beat_err_s;

`ifdef AXI_BURST_MASTER_ID_CHECK_EN
    assign bid_err_s = (bus.m_axi_bid != id_r);
    assign rid_err_s = (bus.m_axi_rid != id_r);
`else
    assign bid_err_s = 1'b0;
    assign rid_err_s = 1'b0;
`endif

    assign wvalid_s = (state_r == WR_DATA) && bus.wr_valid;
    assign wlast_s  = (state_r == WR_DATA) && (beat_cnt_r == len_r);
    assign cmd_hs_s = bus.cmd_valid && cmd_ready_r;
    assign aw_hs_s  = awvalid_r && bus.m_axi_awready;
    assign ar_hs_s  = arvalid_r && bus.m_axi_arready;
    assign w_hs_s   = wvalid_s && bus.m_axi_wready;
    assign b_hs_s   = (state_r == WR_RESP) && bus.m_axi_bvalid;
    assign r_hs_s   = (state_r == RD_DATA) && bus.m_axi_rvalid && bus.rd_ready;

    // A beat past len without rlast is an overrun; it stays sticky even if the counter wraps.
    assign rd_beat_err_s = rd_err_r || (bus.m_axi_rresp != 2'b00) || rid_err_s ||
                           ((beat_cnt_r == len_r) && !bus.m_axi_rlast);

    // Next-state and next-register computation for the burst sequencer.
    always_comb begin
        state_next_s     = state_r;
        cmd_ready_next_s = 1'b0;
        addr_next_s      = addr_r;
        len_next_s       = len_r;
        id_next_s        = id_r;
        awvalid_next_s   = awvalid_r;
        arvalid_next_s   = arvalid_r;
        beat_cnt_next_s  = beat_cnt_r;
        rd_err_next_s    = rd_err_r;
        done_next_s      = 1'b0;
        done_err_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_hs_s) begin
                    addr_next_s     = bus.cmd_addr & ADDR_MASK;
                    len_next_s      = bus.cmd_len;
                    id_next_s       = bus.cmd_id;
                    beat_cnt_next_s = 8'd0;
                    rd_err_next_s   = 1'b0;
                    if (bus.cmd_write) begin
                        state_next_s   = WR_ADDR;
                        awvalid_next_s = 1'b1;
                    end else begin
                        state_next_s   = RD_ADDR;
                        arvalid_next_s = 1'b1;
                    end
                end else begin
                    cmd_ready_next_s = 1'b1;
                end
            end
            WR_ADDR: begin
                if (aw_hs_s) begin
                    awvalid_next_s = 1'b0;
                    state_next_s   = WR_DATA;
                end else begin
                    awvalid_next_s = 1'b1;
                end
            end
            WR_DATA: begin
                if (w_hs_s) begin
                    beat_cnt_next_s = beat_cnt_r + 8'd1;
                    state_next_s    = wlast_s ? WR_RESP : WR_DATA;
                end else begin
                    beat_cnt_next_s = beat_cnt_r;
                end
            end
            WR_RESP: begin
                if (b_hs_s) begin
                    done_next_s     = 1'b1;
                    done_err_next_s = (bus.m_axi_bresp != 2'b00) || bid_err_s;
                    state_next_s    = IDLE;
                end else begin
                    state_next_s    = WR_RESP;
                end
            end
            RD_ADDR: begin
                if (ar_hs_s) begin
                    arvalid_next_s = 1'b0;
                    state_next_s   = RD_DATA;
                end else begin
                    arvalid_next_s = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_hs_s) begin
                    beat_cnt_next_s = beat_cnt_r + 8'd1;
                    rd_err_next_s   = rd_beat_err_s;
                    if (bus.m_axi_rlast) begin
                        done_next_s     = 1'b1;
                        done_err_next_s = rd_beat_err_s || (beat_cnt_r != len_r);
                        state_next_s    = IDLE;
                    end else begin
                        state_next_s    = RD_DATA;
                    end
                end else begin
                    rd_err_next_s = rd_err_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and control registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b0;
            addr_r      <= '0;
            len_r       <= 8'd0;
            id_r        <= '0;
            awvalid_r   <= 1'b0;
            arvalid_r   <= 1'b0;
            beat_cnt_r  <= 8'd0;
            rd_err_r    <= 1'b0;
            done_r      <= 1'b0;
            done_err_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cmd_ready_r <= cmd_ready_next_s;
            addr_r      <= addr_next_s;
            len_r       <= len_next_s;
            id_r        <= id_next_s;
            awvalid_r   <= awvalid_next_s;
            arvalid_r   <= arvalid_next_s;
            beat_cnt_r  <= beat_cnt_next_s;
            rd_err_r    <= rd_err_next_s;
            done_r      <= done_next_s;
            done_err_r  <= done_err_next_s;
        end
    end

    assign bus.cmd_ready     = cmd_ready_r;
    assign bus.done          = done_r;
    assign bus.done_err      = done_err_r;

    assign bus.m_axi_awid    = id_r;
    assign bus.m_axi_awaddr  = addr_r;
    assign bus.m_axi_awlen   = len_r;
    assign bus.m_axi_awsize  = AXI_SIZE;
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awlock  = 1'b0;
    assign bus.m_axi_awcache = 4'b0011;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = awvalid_r;

    assign bus.m_axi_wdata   = bus.wr_data;
    assign bus.m_axi_wstrb   = bus.wr_strb;
    assign bus.m_axi_wlast   = wlast_s;
    assign bus.m_axi_wvalid  = wvalid_s;
    assign bus.wr_ready      = (state_r == WR_DATA) && bus.m_axi_wready;
    assign bus.m_axi_bready  = (state_r == WR_RESP);

    assign bus.m_axi_arid    = id_r;
    assign bus.m_axi_araddr  = addr_r;
    assign bus.m_axi_arlen   = len_r;
    assign bus.m_axi_arsize  = AXI_SIZE;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'b0011;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = arvalid_r;

    assign bus.rd_valid      = (state_r == RD_DATA) && bus.m_axi_rvalid;
    assign bus.m_axi_rready  = (state_r == RD_DATA) && bus.rd_ready;
    assign bus.rd_data       = bus.m_axi_rdata;
    assign bus.rd_last       = bus.m_axi_rlast;
endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized bench for axi_burst_master: acts as caller and AXI slave, checks against a burst-level model.
module tb_axi_burst_master;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_burst_master_if bus ();
    axi_burst_master dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef AXI_BURST_MASTER_ID_CHECK_EN
    localparam bit ID_CHK = 1'b1;
`else
    localparam bit ID_CHK = 1'b0;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_id = '0;
        bus.wr_data = '0; bus.wr_strb = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_arready = 1'b0;
        bus.m_axi_bid = '0; bus.m_axi_bresp = 2'b00; bus.m_axi_bvalid = 1'b0;
        bus.m_axi_rid = '0; bus.m_axi_rdata = '0; bus.m_axi_rresp = 2'b00;
        bus.m_axi_rlast = 1'b0; bus.m_axi_rvalid = 1'b0;
    endtask

    function automatic logic [9:0] quiet_vec();
        return {bus.cmd_ready, bus.done, bus.done_err, bus.m_axi_awvalid, bus.m_axi_arvalid,
                bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_rready, bus.wr_ready, bus.rd_valid};
    endfunction

    task automatic run_write(input logic [15:0] addr, input logic [7:0] len, input logic [7:0] id,
                             input logic [1:0] bresp, input logic [7:0] bid, input int aw_stall,
                             input bit rnd, input int abort_at);
        logic [31:0] wd[$];
        logic [3:0]  ws[$];
        logic [15:0] exp_addr = addr & 16'hFFFC;
        bit exp_err = (bresp != 2'b00) || (ID_CHK && (bid != id));
        bit acc = 0, aw_ok = 0, b_pend = 0, b_ok = 0, got_done = 0, wv = 0;
        int wi = 0, aw_wait = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wd.push_back($urandom);
            ws.push_back(4'($urandom_range(0, 15)));
        end
        idle_inputs();
        bus.cmd_write = 1'b1; bus.cmd_addr = addr; bus.cmd_len = len; bus.cmd_id = id;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = !acc;
            bus.m_axi_awready = (aw_wait >= aw_stall);
            if (!wv) wv = (wi <= int'(len)) && (!rnd || $urandom_range(0, 2) != 0);
            bus.wr_valid = wv;
            bus.wr_data = wv ? wd[wi] : 32'd0;
            bus.wr_strb = wv ? ws[wi] : 4'd0;
            bus.m_axi_wready = !rnd || ($urandom_range(0, 1) == 1);
            bus.m_axi_bvalid = b_pend; bus.m_axi_bresp = bresp; bus.m_axi_bid = bid;
            #1;
            if (abort_at >= 0 && wi == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_mid_burst_quiet", quiet_vec(), 10'd0);
                idle_inputs();
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1 check_eq("rst_no_done", bus.done, 1'b0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                #1 check_eq("cmd_ready_after_rst", bus.cmd_ready, 1'b1);
                return;
            end
            if (acc && !aw_ok) check_eq("awvalid_held", bus.m_axi_awvalid, 1'b1);
            if (bus.cmd_valid && bus.cmd_ready) acc = 1;
            if (bus.m_axi_awvalid) begin
                check_eq("awaddr", bus.m_axi_awaddr, exp_addr);
                if (bus.m_axi_awready) begin
                    check_eq("awlen", bus.m_axi_awlen, len);
                    check_eq("awid", bus.m_axi_awid, id);
                    check_eq("awsize", bus.m_axi_awsize, 3'd2);
                    check_eq("aw_attr", {bus.m_axi_awburst, bus.m_axi_awlock, bus.m_axi_awcache, bus.m_axi_awprot},
                             {2'b01, 1'b0, 4'b0011, 3'b000});
                    aw_ok = 1;
                end else aw_wait++;
            end
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                check_eq("wdata", bus.m_axi_wdata, wd[wi]);
                check_eq("wstrb", bus.m_axi_wstrb, ws[wi]);
                check_eq("wlast", bus.m_axi_wlast, wi == int'(len));
                check_eq("wr_ready", bus.wr_ready, 1'b1);
                wi++;
                wv = 0;
                if (wi == int'(len) + 1) b_pend = 1;
            end
            if (bus.m_axi_bvalid && bus.m_axi_bready) begin
                b_pend = 0;
                b_ok = 1;
            end
            if (bus.done) begin
                got_done = 1;
                check_eq("wr_done_after_b", b_ok, 1'b1);
                check_eq("wr_beats", wi, int'(len) + 1);
                check_eq("wr_done_err", bus.done_err, exp_err);
            end
        end
        check_eq("wr_done_seen", got_done, 1'b1);
        idle_inputs();
        @(negedge clk);
        #1 check_eq("cmd_ready_after_wr_done", bus.cmd_ready, 1'b1);
    endtask

    task automatic run_read(input logic [15:0] addr, input logic [7:0] len, input logic [7:0] id,
                            input int nbeats, input int err_beat, input logic [7:0] rid,
                            input bit rnd, input bit tog);
        logic [31:0] rq[$];
        logic [15:0] exp_addr = addr & 16'hFFFC;
        bit exp_err = (err_beat >= 0 && err_beat < nbeats) || (nbeats != int'(len) + 1) ||
                      (ID_CHK && (rid != id));
        bit acc = 0, ar_ok = 0, rv = 0, got_done = 0;
        int ri = 0;
        for (int i = 0; i < nbeats; i++) rq.push_back($urandom);
        idle_inputs();
        bus.cmd_write = 1'b0; bus.cmd_addr = addr; bus.cmd_len = len; bus.cmd_id = id;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = !acc;
            bus.m_axi_arready = !rnd || ($urandom_range(0, 1) == 1);
            if (!rv) rv = ar_ok && (ri < nbeats) && (!rnd || $urandom_range(0, 2) != 0);
            bus.m_axi_rvalid = rv;
            bus.m_axi_rdata = rv ? rq[ri] : 32'd0;
            bus.m_axi_rlast = rv && (ri == nbeats - 1);
            bus.m_axi_rresp = (rv && ri == err_beat) ? 2'b10 : 2'b00;
            bus.m_axi_rid = rid;
            bus.rd_ready = !tog || ($urandom_range(0, 1) == 1);
            #1;
            if (acc && !ar_ok) check_eq("arvalid_held", bus.m_axi_arvalid, 1'b1);
            if (bus.cmd_valid && bus.cmd_ready) acc = 1;
            if (bus.m_axi_arvalid) begin
                check_eq("araddr", bus.m_axi_araddr, exp_addr);
                if (bus.m_axi_arready) begin
                    check_eq("arlen", bus.m_axi_arlen, len);
                    check_eq("arid", bus.m_axi_arid, id);
                    check_eq("arsize", bus.m_axi_arsize, 3'd2);
                    check_eq("ar_attr", {bus.m_axi_arburst, bus.m_axi_arlock, bus.m_axi_arcache, bus.m_axi_arprot},
                             {2'b01, 1'b0, 4'b0011, 3'b000});
                    ar_ok = 1;
                end
            end
            if (bus.m_axi_rvalid) check_eq("rready_pass", bus.m_axi_rready, bus.rd_ready);
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                check_eq("rd_valid", bus.rd_valid, 1'b1);
                check_eq("rd_data", bus.rd_data, rq[ri]);
                check_eq("rd_last", bus.rd_last, ri == nbeats - 1);
                ri++;
                rv = 0;
            end
            if (bus.done) begin
                got_done = 1;
                check_eq("rd_beats", ri, nbeats);
                check_eq("rd_done_err", bus.done_err, exp_err);
            end
        end
        check_eq("rd_done_seen", got_done, 1'b1);
        idle_inputs();
        @(negedge clk);
        #1 check_eq("cmd_ready_after_rd_done", bus.cmd_ready, 1'b1);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_eq("reset_quiet", quiet_vec(), 10'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check_eq("cmd_ready_first_edge", bus.cmd_ready, 1'b1);

        run_write(16'h0103, 8'd3, 8'h5A, 2'b00, 8'h5A, 0, 1'b0, -1);
        run_read(16'h0200, 8'd7, 8'h33, 8, -1, 8'h33, 1'b0, 1'b1);
        run_read(16'h0040, 8'd1, 8'h07, 2, 0, 8'h07, 1'b0, 1'b0);
        run_read(16'h0080, 8'd3, 8'h08, 3, -1, 8'h08, 1'b0, 1'b0);
        run_read(16'h00C1, 8'd1, 8'h09, 4, -1, 8'h09, 1'b1, 1'b1);
        run_write(16'h0302, 8'd2, 8'h44, 2'b00, 8'h44, 10, 1'b0, -1);
        run_write(16'h0407, 8'd0, 8'h45, 2'b10, 8'h45, 0, 1'b1, -1);
        run_write(16'h0500, 8'd7, 8'h46, 2'b00, 8'h46, 0, 1'b0, 2);
        run_write(16'h0600, 8'd1, 8'h22, 2'b00, 8'h11, 0, 1'b0, -1);
        run_read(16'h0700, 8'd1, 8'h22, 2, -1, 8'h11, 1'b0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            logic [15:0] a;
            logic [7:0]  l, id;
            int nb, eb;
            a  = 16'($urandom_range(0, 65535));
            l  = 8'($urandom_range(0, 15));
            id = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                run_write(a, l, id, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                          ($urandom_range(0, 3) == 0) ? ~id : id, $urandom_range(0, 3), 1'b1, -1);
            end else begin
                nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(l) + 3) : int'(l) + 1;
                eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
                run_read(a, l, id, nb, eb, ($urandom_range(0, 3) == 0) ? ~id : id, 1'b1, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
